// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiply sequencer: state encoding and
// default sizing.
package mul_seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the iteration counter has reached the final add/shift step.
    function automatic logic last_iter(input logic [7:0] cnt, input int width);
        return (int'(cnt) == (width - 1));
    endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle unsigned shift-add multiplier sequencer; borrows an external
// WIDTH-bit adder for one add per cycle and holds the product until consumed.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_prod,
    output logic                 rsp_hi_nz,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    output logic                 add_sub,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   m_r;
    logic [WIDTH-1:0]   m_s;
    logic [WIDTH-1:0]   ph_r;
    logic [WIDTH-1:0]   ph_s;
    logic [WIDTH-1:0]   pl_r;
    logic [WIDTH-1:0]   pl_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [7:0]         cnt_ext_s;

    logic               req_ready_r;
    logic               rsp_valid_r;
    logic               rsp_hi_nz_r;
    logic [WIDTH-1:0]   add_a_r;
    logic [WIDTH-1:0]   add_b_r;
    logic [WIDTH-1:0]   add_a_s;
    logic [WIDTH-1:0]   add_b_s;

    assign cnt_ext_s = 8'(cnt_r);

    // Next-state and datapath register update.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        ph_s    = ph_r;
        pl_s    = pl_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    m_s     = req_a;
                    ph_s    = {WIDTH{1'b0}};
                    pl_s    = req_b;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // Carry-out becomes the new PH MSB, so nothing overflows.
                {ph_s, pl_s} = {add_cout, add_s, pl_r[WIDTH-1:1]};
                cnt_s        = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (last_iter(cnt_ext_s, WIDTH)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Adder operands for the cycle following the edge, so they come from flops.
    always_comb begin
        add_a_s = {WIDTH{1'b0}};
        add_b_s = {WIDTH{1'b0}};
        if (state_s == RUN) begin
            add_a_s = ph_s;
            if (pl_s[0]) begin
                add_b_s = m_s;
            end else begin
                add_b_s = {WIDTH{1'b0}};
            end
        end else begin
            add_a_s = {WIDTH{1'b0}};
            add_b_s = {WIDTH{1'b0}};
        end
    end

    // State, datapath and registered output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            m_r         <= {WIDTH{1'b0}};
            ph_r        <= {WIDTH{1'b0}};
            pl_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_hi_nz_r <= 1'b0;
            add_a_r     <= {WIDTH{1'b0}};
            add_b_r     <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            m_r         <= m_s;
            ph_r        <= ph_s;
            pl_r        <= pl_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == IDLE);
            rsp_valid_r <= (state_s == DONE);
            rsp_hi_nz_r <= |ph_s;
            add_a_r     <= add_a_s;
            add_b_r     <= add_b_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_prod  = {ph_r, pl_r};
    assign rsp_hi_nz = rsp_hi_nz_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = 1'b0;
    assign add_sub   = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench: wraps the sequencer with a behavioural add/sub unit and
// compares every product against plain integer multiplication.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_prod;
    logic               rsp_hi_nz;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic               add_sub;
    logic [WIDTH-1:0]   add_s;
    logic               add_cout;
    logic [WIDTH:0]     add_full;

    int n_checks;
    int n_errors;

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_hi_nz (rsp_hi_nz),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sub   (add_sub),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // Shared add/sub unit as seen at the ALU level.
    assign add_full = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {{WIDTH{1'b0}}, add_cin};
    assign add_s    = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply: accept, watch RUN, check the response, optionally stall the
    // consumer for 'hold' cycles while a second request waits on req_valid.
    task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input logic queue_next,
                          input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
        logic [2*WIDTH-1:0] exp_prod;
        logic [2*WIDTH-1:0] held;
        int cycles;
        exp_prod = (2*WIDTH)'(longint'(a) * longint'(b));
        check_val("ready_before_accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        tick();
        req_valid = 1'b0;
        cycles = 0;
        while (!rsp_valid && cycles < 40) begin
            if (req_ready !== 1'b0) check_val("ready_low_in_run", 64'(req_ready), 64'd0);
            if (b == '0) check_val("add_b_zero_mult", 64'(add_b), 64'd0);
            tick();
            cycles++;
        end
        check_val("latency", 64'(cycles), 64'(WIDTH));
        check_val("prod", 64'(rsp_prod), 64'(exp_prod));
        check_val("hi_nz", 64'(rsp_hi_nz), 64'(exp_prod[2*WIDTH-1:WIDTH] != '0));
        check_val("add_a_done", 64'(add_a), 64'd0);
        check_val("ready_low_done", 64'(req_ready), 64'd0);
        held = rsp_prod;
        if (hold > 0) begin
            if (queue_next) begin
                req_valid = 1'b1;
                req_a     = a2;
                req_b     = b2;
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                check_val("hold_valid", 64'(rsp_valid), 64'd1);
                check_val("hold_prod", 64'(rsp_prod), 64'(held));
                check_val("hold_ready", 64'(req_ready), 64'd0);
            end
            rsp_ready = 1'b1;
        end
        tick();
        rsp_ready = 1'b0;
        check_val("valid_drop", 64'(rsp_valid), 64'd0);
        check_val("ready_back", 64'(req_ready), 64'd1);
        check_val("prod_kept", 64'(rsp_prod), 64'(held));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_prod", 64'(rsp_prod), 64'd0);
        check_val("rst_hi_nz", 64'(rsp_hi_nz), 64'd0);
        check_val("rst_add_a", 64'(add_a), 64'd0);
        check_val("rst_add_b", 64'(add_b), 64'd0);
        check_val("add_ctl", 64'({add_cin, add_sub}), 64'd0);

        do_mul(16'd3,      16'd5,      0, 1'b0, '0, '0);
        do_mul(16'hFFFF,   16'hFFFF,   0, 1'b0, '0, '0);
        do_mul(16'h8000,   16'h0002,   0, 1'b0, '0, '0);
        do_mul(16'h1234,   16'h0000,   0, 1'b0, '0, '0);
        do_mul(16'h0000,   16'hBEEF,   0, 1'b0, '0, '0);

        // Backpressure with a queued request that must wait for IDLE.
        do_mul(16'h00AB, 16'h0CD0, 5, 1'b1, 16'h0011, 16'h0022);
        check_val("queued_still_waiting", 64'(req_valid), 64'd1);
        do_mul(16'h0011, 16'h0022, 0, 1'b0, '0, '0);

        // Reset in the middle of a run.
        req_valid = 1'b1;
        req_a     = 16'hABCD;
        req_b     = 16'h4321;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_valid", 64'(rsp_valid), 64'd0);
        check_val("midrst_prod", 64'(rsp_prod), 64'd0);
        check_val("midrst_ready", 64'(req_ready), 64'd1);
        check_val("midrst_add_a", 64'(add_a), 64'd0);
        do_mul(16'd7, 16'd9, 0, 1'b0, '0, '0);

        for (int t = 0; t < 25; t++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (t % 5 == 0) rb = WIDTH'(16'h1) << $urandom_range(0, WIDTH-1);
            do_mul(ra, rb, $urandom_range(0, 3), 1'b0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
